// File: rtl/poly_ucode_if.sv
// Host/datapath-side bundle for the polynomial microcode sequencer.
// master = host and datapath; slave = sequencer.
interface poly_ucode_if #(
  parameter int ADDR_W = 4
);
  logic              i_prog_we;
  logic [ADDR_W-1:0] i_prog_addr;
  logic [11:0]       i_prog_data;
  logic              i_start;
  logic [ADDR_W-1:0] i_start_addr;
  logic              i_abort;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic              o_ld_a;
  logic              o_ld_b;
  logic              o_ld_c;
  logic              o_ld_x;
  logic              o_ld_r;
  logic              o_ld_alu_out;
  logic [1:0]        o_alu_select_a;
  logic [1:0]        o_alu_select_b;
  logic              o_alu_op;

  modport master (
    output i_prog_we, i_prog_addr, i_prog_data,
    output i_start, i_start_addr, i_abort,
    input  o_busy, o_done, o_error,
    input  o_ld_a, o_ld_b, o_ld_c, o_ld_x, o_ld_r,
    input  o_ld_alu_out, o_alu_select_a,
    input  o_alu_select_b, o_alu_op
  );

  modport slave (
    input  i_prog_we, i_prog_addr, i_prog_data,
    input  i_start, i_start_addr, i_abort,
    output o_busy, o_done, o_error,
    output o_ld_a, o_ld_b, o_ld_c, o_ld_x, o_ld_r,
    output o_ld_alu_out, o_alu_select_a,
    output o_alu_select_b, o_alu_op
  );
endinterface

// File: rtl/poly_ucode_sequencer.sv
// Microcoded sequencer driving the 8-bit polynomial datapath controls.
// One micro-instruction issues per cycle until a word carries the last bit.
module poly_ucode_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  poly_ucode_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(PROG_DEPTH - 1);
  localparam logic [11:0] NOP_WORD = 12'h800;

  state_t            r_state;
  state_t            w_next;
  logic [11:0]       r_store [PROG_DEPTH];
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_iaddr;
  logic [11:0]       r_ir;
  logic              r_error;

  logic w_last;
  logic w_ovf;
  logic w_we;
  logic w_accept;
  logic w_fetch;

  assign w_last   = r_ir[11];
  assign w_ovf    = !w_last && (r_iaddr == LAST_ADDR);
  assign w_we     = bus.i_prog_we &&
                    (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept = (r_state == S_IDLE) && bus.i_start;
  assign w_fetch  = !bus.i_abort &&
                    ((r_state == S_PRIME) ||
                     (r_state == S_RUN && !w_last && !w_ovf));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        r_store[i] <= NOP_WORD;
      end
    end else if (w_we) begin
      r_store[bus.i_prog_addr] <= bus.i_prog_data;
    end
  end

  // pc saturates at the top word; the overrun check stops the run there
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_iaddr <= '0;
      r_ir    <= '0;
    end else if (w_accept) begin
      r_pc <= bus.i_start_addr;
    end else if (w_fetch) begin
      r_ir    <= r_store[r_pc];
      r_iaddr <= r_pc;
      if (r_pc != LAST_ADDR) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= 1'b0;
    end else if (r_state == S_RUN &&
                 !bus.i_abort && w_ovf) begin
      r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = S_PRIME;
      end
      S_PRIME: begin
        w_next = bus.i_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.i_abort)  w_next = S_IDLE;
        else if (w_last)  w_next = S_DONE;
        else if (w_ovf)   w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy         = 1'b0;
    bus.o_done         = 1'b0;
    bus.o_error        = r_error;
    bus.o_ld_r         = 1'b0;
    bus.o_ld_alu_out   = 1'b0;
    bus.o_ld_x         = 1'b0;
    bus.o_ld_c         = 1'b0;
    bus.o_ld_b         = 1'b0;
    bus.o_ld_a         = 1'b0;
    bus.o_alu_select_a = 2'd0;
    bus.o_alu_select_b = 2'd0;
    bus.o_alu_op       = 1'b0;
    unique case (r_state)
      S_PRIME: begin
        bus.o_busy = 1'b1;
      end
      S_RUN: begin
        bus.o_busy         = 1'b1;
        bus.o_ld_r         = r_ir[10];
        bus.o_ld_alu_out   = r_ir[9];
        bus.o_ld_x         = r_ir[8];
        bus.o_ld_c         = r_ir[7];
        bus.o_ld_b         = r_ir[6];
        bus.o_ld_a         = r_ir[5];
        bus.o_alu_select_a = r_ir[4:3];
        bus.o_alu_select_b = r_ir[2:1];
        bus.o_alu_op       = r_ir[0];
      end
      S_DONE: begin
        bus.o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
